// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types, control presets and helpers for the pipeline hazard controller.
package hazard_ctrl_pkg;

    // Operand source select for the EX-stage rs1/rs2 muxes.
    typedef enum logic [1:0] {
        FWD_NONE  = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    // INIT clears the pipe, RUN is normal operation, DROP squashes a stale in-flight fetch.
    typedef enum logic [1:0] {
        INIT = 2'b00,
        RUN  = 2'b01,
        DROP = 2'b10
    } hazard_state_t;

    // Bit positions inside the per-stage vectors of pipe_ctrl_t.
    localparam int STG_IFID  = 3;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 1;
    localparam int STG_MEMWB = 0;

    // Stage vectors are ordered {ifid, idex, exmem, memwb}.
    typedef struct packed {
        logic       load_pc;
        logic [3:0] pipe_load;
        logic [3:0] pipe_rst;
    } pipe_ctrl_t;

    // Clear every pipeline register and keep the PC where it is.
    localparam pipe_ctrl_t CTRL_RESET   = '{load_pc: 1'b0, pipe_load: 4'b0000, pipe_rst: 4'b1111};
    // Freeze everything, including the PC.
    localparam pipe_ctrl_t CTRL_HOLD    = '{load_pc: 1'b0, pipe_load: 4'b0000, pipe_rst: 4'b0000};
    // Every stage and the PC advance.
    localparam pipe_ctrl_t CTRL_ADVANCE = '{load_pc: 1'b1, pipe_load: 4'b1111, pipe_rst: 4'b0000};
    // Redirect the PC and squash the two younger slots; the older stages keep flowing.
    localparam pipe_ctrl_t CTRL_FLUSH   = '{load_pc: 1'b1, pipe_load: 4'b1111, pipe_rst: 4'b1100};
    // Keep PC and IF/ID, push a bubble into ID/EX, let the older stages drain.
    localparam pipe_ctrl_t CTRL_BUBBLE  = '{load_pc: 1'b0, pipe_load: 4'b0111, pipe_rst: 4'b0100};

    // EX/MEM is the younger producer so it wins over MEM/WB; x0 is never forwarded.
    function automatic fwd_sel_t fwd_pick(input logic [4:0] rs,
                                          input logic [4:0] exmem_rd,
                                          input logic       exmem_we,
                                          input logic [4:0] memwb_rd,
                                          input logic       memwb_we);
        fwd_sel_t sel;
        sel = FWD_NONE;
        if (exmem_we && (exmem_rd != 5'd0) && (exmem_rd == rs)) begin
            sel = FWD_EXMEM;
        end else if (memwb_we && (memwb_rd != 5'd0) && (memwb_rd == rs)) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-register fields and cache handshakes in, stall/flush/forward controls out.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
    import hazard_ctrl_pkg::*;

    logic             imem_resp;
    logic             dmem_resp;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       idex_rs1;
    logic [4:0]       idex_rs2;
    logic [4:0]       idex_rd;
    logic             idex_dcache_read;
    logic [4:0]       exmem_rd;
    logic             exmem_load_regfile;
    logic             exmem_dcache_read;
    logic             exmem_dcache_write;
    logic [4:0]       memwb_rd;
    logic             memwb_load_regfile;
    logic             ex_br_taken;

    logic             load_pc;
    logic             pipe_load_ifid;
    logic             pipe_load_idex;
    logic             pipe_load_exmem;
    logic             pipe_load_memwb;
    logic             pipe_rst_ifid;
    logic             pipe_rst_idex;
    logic             pipe_rst_exmem;
    logic             pipe_rst_memwb;
    fwd_sel_t         rs1mux_sel;
    fwd_sel_t         rs2mux_sel;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // The datapath side: supplies pipeline fields, consumes the controls.
    modport master (
        output imem_resp, dmem_resp, id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd,
               idex_dcache_read, exmem_rd, exmem_load_regfile, exmem_dcache_read,
               exmem_dcache_write, memwb_rd, memwb_load_regfile, ex_br_taken,
        input  load_pc, pipe_load_ifid, pipe_load_idex, pipe_load_exmem, pipe_load_memwb,
               pipe_rst_ifid, pipe_rst_idex, pipe_rst_exmem, pipe_rst_memwb,
               rs1mux_sel, rs2mux_sel, stall_cnt, flush_cnt
    );

    // The hazard controller side.
    modport slave (
        input  imem_resp, dmem_resp, id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd,
               idex_dcache_read, exmem_rd, exmem_load_regfile, exmem_dcache_read,
               exmem_dcache_write, memwb_rd, memwb_load_regfile, ex_br_taken,
        output load_pc, pipe_load_ifid, pipe_load_idex, pipe_load_exmem, pipe_load_memwb,
               pipe_rst_ifid, pipe_rst_idex, pipe_rst_exmem, pipe_rst_memwb,
               rs1mux_sel, rs2mux_sel, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_ctrl_forwarding_unit.sv
// forwarding_unit: combinational EX operand bypass selection for rs1 and rs2.
module forwarding_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] idex_rs1_i,
    input  logic [4:0] idex_rs2_i,
    input  logic [4:0] exmem_rd_i,
    input  logic       exmem_load_regfile_i,
    input  logic [4:0] memwb_rd_i,
    input  logic       memwb_load_regfile_i,
    output fwd_sel_t   rs1mux_sel_o,
    output fwd_sel_t   rs2mux_sel_o
);

    // Both operands use the same priority: newest in-flight writer first.
    always_comb begin
        rs1mux_sel_o = fwd_pick(idex_rs1_i, exmem_rd_i, exmem_load_regfile_i,
                                memwb_rd_i, memwb_load_regfile_i);
        rs2mux_sel_o = fwd_pick(idex_rs2_i, exmem_rd_i, exmem_load_regfile_i,
                                memwb_rd_i, memwb_load_regfile_i);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: single owner of stall, flush, bubble and forwarding decisions for the 5-stage core.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave hz_io
);

    hazard_state_t    state_q;
    hazard_state_t    state_d;
    pipe_ctrl_t       ctrl;
    logic             dstall;
    logic             istall;
    logic             load_use;
    logic             stall_inc;
    logic             flush_inc;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    assign dstall   = (hz_io.exmem_dcache_read | hz_io.exmem_dcache_write) & ~hz_io.dmem_resp;
    assign istall   = ~hz_io.imem_resp;
    assign load_use = hz_io.idex_dcache_read && (hz_io.idex_rd != 5'd0) &&
                      ((hz_io.idex_rd == hz_io.id_rs1) || (hz_io.idex_rd == hz_io.id_rs2));

    // Next state and pipe controls; counting only happens for RUN-state decisions.
    always_comb begin
        state_d   = state_q;
        ctrl      = CTRL_RESET;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (rst) begin
            state_d = INIT;
            ctrl    = CTRL_RESET;
        end else begin
            case (state_q)
                INIT: begin
                    ctrl    = CTRL_RESET;
                    state_d = RUN;
                end
                RUN: begin
                    if (dstall) begin
                        ctrl      = CTRL_HOLD;
                        stall_inc = 1'b1;
                    end else if (istall) begin
                        ctrl      = CTRL_HOLD;
                        stall_inc = 1'b1;
                        if (hz_io.ex_br_taken) begin
                            // Redirect now; the fetch still in flight is stale and gets dropped later.
                            ctrl.load_pc            = 1'b1;
                            ctrl.pipe_rst[STG_IFID] = 1'b1;
                            ctrl.pipe_rst[STG_IDEX] = 1'b1;
                            state_d                 = DROP;
                        end
                    end else if (hz_io.ex_br_taken) begin
                        ctrl      = CTRL_FLUSH;
                        flush_inc = 1'b1;
                    end else if (load_use) begin
                        ctrl      = CTRL_BUBBLE;
                        stall_inc = 1'b1;
                    end else begin
                        ctrl = CTRL_ADVANCE;
                    end
                end
                DROP: begin
                    ctrl = CTRL_HOLD;
                    if (!dstall && hz_io.imem_resp) begin
                        // This response answers the pre-redirect PC: discard it, keep the new PC.
                        ctrl.pipe_rst[STG_IFID] = 1'b1;
                        state_d                 = RUN;
                    end
                end
                default: begin
                    ctrl    = CTRL_RESET;
                    state_d = INIT;
                end
            endcase
        end
    end

    // Performance counters wrap naturally at 2^CNT_W.
    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(stall_inc);
        flush_cnt_d = flush_cnt_q + CNT_W'(flush_inc);
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz_io.load_pc         = ctrl.load_pc;
    assign hz_io.pipe_load_ifid  = ctrl.pipe_load[STG_IFID];
    assign hz_io.pipe_load_idex  = ctrl.pipe_load[STG_IDEX];
    assign hz_io.pipe_load_exmem = ctrl.pipe_load[STG_EXMEM];
    assign hz_io.pipe_load_memwb = ctrl.pipe_load[STG_MEMWB];
    assign hz_io.pipe_rst_ifid   = ctrl.pipe_rst[STG_IFID];
    assign hz_io.pipe_rst_idex   = ctrl.pipe_rst[STG_IDEX];
    assign hz_io.pipe_rst_exmem  = ctrl.pipe_rst[STG_EXMEM];
    assign hz_io.pipe_rst_memwb  = ctrl.pipe_rst[STG_MEMWB];
    assign hz_io.stall_cnt       = stall_cnt_q;
    assign hz_io.flush_cnt       = flush_cnt_q;

    forwarding_unit u_fwd (
        .idex_rs1_i           (hz_io.idex_rs1),
        .idex_rs2_i           (hz_io.idex_rs2),
        .exmem_rd_i           (hz_io.exmem_rd),
        .exmem_load_regfile_i (hz_io.exmem_load_regfile),
        .memwb_rd_i           (hz_io.memwb_rd),
        .memwb_load_regfile_i (hz_io.memwb_load_regfile),
        .rs1mux_sel_o         (hz_io.rs1mux_sel),
        .rs2mux_sel_o         (hz_io.rs2mux_sel)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table plus scoreboard for hazard_ctrl, small counters so wrap is reachable.
module tb_hazard_ctrl;

    localparam int CW = 4;

    // Expected control word: {load_pc, load ifid/idex/exmem/memwb, rst ifid/idex/exmem/memwb}.
    localparam logic [8:0] E_RESET = 9'b0_0000_1111;
    localparam logic [8:0] E_HOLD  = 9'b0_0000_0000;
    localparam logic [8:0] E_ADV   = 9'b1_1111_0000;
    localparam logic [8:0] E_FLUSH = 9'b1_1111_1100;
    localparam logic [8:0] E_LU    = 9'b0_0111_0100;
    localparam logic [8:0] E_DROP  = 9'b1_0000_1100;
    localparam logic [8:0] E_STALE = 9'b0_0000_1000;

    typedef struct {
        string      name;
        logic       rst;
        logic       imem;
        logic       dmem;
        logic       dRead;
        logic       dWr;
        logic       br;
        logic       ldRead;
        logic [4:0] ldRd;
        logic [4:0] exRd;
        logic       exWe;
        logic [4:0] wbRd;
        logic       wbWe;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [8:0] expCtrl;
        logic [1:0] expRs1;
        logic [1:0] expRs2;
        int         expStall;
        int         expFlush;
    } vec_t;

    logic clk;
    logic rst;
    vec_t vecs[$];
    vec_t expQ[$];
    int   total;
    int   bad;

    hazard_ctrl_if #(.CNT_W(CW)) hif ();

    hazard_ctrl #(.CNT_W(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .hz_io (hif)
    );

    // Free-running core clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: act=timeout req=summary");
        $fatal(1, "[TB] watchdog expired");
    end

    // Hazard-flow vector: forwarding fields idle, id_rs1=0 and id_rs2=7 fixed.
    function automatic vec_t hz(string n, logic r, logic im, logic dm, logic dr, logic dw,
                                logic b, logic lr, logic [4:0] lrd, logic [8:0] ec, int es, int ef);
        vec_t v;
        v.name = n; v.rst = r; v.imem = im; v.dmem = dm; v.dRead = dr; v.dWr = dw;
        v.br = b; v.ldRead = lr; v.ldRd = lrd;
        v.exRd = 5'd0; v.exWe = 1'b0; v.wbRd = 5'd0; v.wbWe = 1'b0; v.rs1 = 5'd0; v.rs2 = 5'd0;
        v.expCtrl = ec; v.expRs1 = 2'b00; v.expRs2 = 2'b00; v.expStall = es; v.expFlush = ef;
        return v;
    endfunction

    // Forwarding vector: pipe otherwise advancing normally with counters at zero.
    function automatic vec_t fw(string n, logic [4:0] er, logic ew, logic [4:0] wr, logic ww,
                                logic [4:0] s1, logic [4:0] s2, logic [1:0] e1, logic [1:0] e2);
        vec_t v;
        v = hz(n, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, E_ADV, 0, 0);
        v.exRd = er; v.exWe = ew; v.wbRd = wr; v.wbWe = ww; v.rs1 = s1; v.rs2 = s2;
        v.expRs1 = e1; v.expRs2 = e2;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst                    = v.rst;
        hif.imem_resp          = v.imem;
        hif.dmem_resp          = v.dmem;
        hif.exmem_dcache_read  = v.dRead;
        hif.exmem_dcache_write = v.dWr;
        hif.ex_br_taken        = v.br;
        hif.idex_dcache_read   = v.ldRead;
        hif.idex_rd            = v.ldRd;
        hif.id_rs1             = 5'd0;
        hif.id_rs2             = 5'd7;
        hif.exmem_rd           = v.exRd;
        hif.exmem_load_regfile = v.exWe;
        hif.memwb_rd           = v.wbRd;
        hif.memwb_load_regfile = v.wbWe;
        hif.idex_rs1           = v.rs1;
        hif.idex_rs2           = v.rs2;
        expQ.push_back(v);
    endtask

    task automatic cmp(input string n, input string what, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s/%s: act=%0h req=%0h", n, what, act, req);
        end
    endtask

    task automatic checkOutput();
        vec_t       e;
        logic [8:0] actCtrl;
        if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard: act=empty req=entry");
            return;
        end
        e = expQ.pop_front();
        actCtrl = {hif.load_pc, hif.pipe_load_ifid, hif.pipe_load_idex, hif.pipe_load_exmem,
                   hif.pipe_load_memwb, hif.pipe_rst_ifid, hif.pipe_rst_idex, hif.pipe_rst_exmem,
                   hif.pipe_rst_memwb};
        cmp(e.name, "ctrl", 32'(actCtrl), 32'(e.expCtrl));
        cmp(e.name, "rs1sel", 32'(hif.rs1mux_sel), 32'(e.expRs1));
        cmp(e.name, "rs2sel", 32'(hif.rs2mux_sel), 32'(e.expRs2));
        cmp(e.name, "stall_cnt", 32'(hif.stall_cnt), 32'(e.expStall % 16));
        cmp(e.name, "flush_cnt", 32'(hif.flush_cnt), 32'(e.expFlush % 16));
    endtask

    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        applyStimulus(v);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        applyStimulus(hz("pre", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, E_RESET, 0, 0));
        void'(expQ.pop_front());
        repeat (2) @(posedge clk);

        vecs.push_back(hz("rst",            1, 1, 0, 0, 0, 0, 0, 5'd0, E_RESET, 0, 0));
        vecs.push_back(hz("init",           0, 1, 0, 0, 0, 0, 0, 5'd0, E_RESET, 0, 0));
        vecs.push_back(hz("advance",        0, 1, 0, 0, 0, 0, 0, 5'd0, E_ADV,   0, 0));
        vecs.push_back(hz("advance2",       0, 1, 0, 0, 0, 0, 0, 5'd0, E_ADV,   0, 0));
        vecs.push_back(hz("load_use",       0, 1, 0, 0, 0, 0, 1, 5'd7, E_LU,    0, 0));
        vecs.push_back(hz("after_bubble",   0, 1, 0, 0, 0, 0, 0, 5'd7, E_ADV,   1, 0));
        vecs.push_back(hz("load_rd0",       0, 1, 0, 0, 0, 0, 1, 5'd0, E_ADV,   1, 0));
        vecs.push_back(hz("load_nomatch",   0, 1, 0, 0, 0, 0, 1, 5'd3, E_ADV,   1, 0));
        vecs.push_back(hz("dstall_br1",     0, 1, 0, 1, 0, 1, 0, 5'd0, E_HOLD,  1, 0));
        vecs.push_back(hz("dstall_br2",     0, 1, 0, 1, 0, 1, 0, 5'd0, E_HOLD,  2, 0));
        vecs.push_back(hz("dstall_br3",     0, 1, 0, 1, 0, 1, 0, 5'd0, E_HOLD,  3, 0));
        vecs.push_back(hz("dresp_flush",    0, 1, 1, 1, 0, 1, 0, 5'd0, E_FLUSH, 4, 0));
        vecs.push_back(hz("post_flush",     0, 1, 0, 0, 0, 0, 0, 5'd0, E_ADV,   4, 1));
        vecs.push_back(hz("flush_beats_lu", 0, 1, 0, 0, 0, 1, 1, 5'd7, E_FLUSH, 4, 1));
        vecs.push_back(hz("post_flush2",    0, 1, 0, 0, 0, 0, 0, 5'd0, E_ADV,   4, 2));
        vecs.push_back(hz("istall",         0, 0, 0, 0, 0, 0, 0, 5'd0, E_HOLD,  4, 2));
        vecs.push_back(hz("dwrite_stall",   0, 1, 0, 0, 1, 0, 0, 5'd0, E_HOLD,  5, 2));
        vecs.push_back(hz("dwrite_done",    0, 1, 1, 0, 1, 0, 0, 5'd0, E_ADV,   6, 2));
        vecs.push_back(hz("dstall_over_is", 0, 0, 0, 1, 0, 1, 0, 5'd0, E_HOLD,  6, 2));
        vecs.push_back(hz("drop_entry",     0, 0, 0, 0, 0, 1, 0, 5'd0, E_DROP,  7, 2));
        vecs.push_back(hz("drop_wait",      0, 0, 0, 0, 0, 0, 0, 5'd0, E_HOLD,  8, 2));
        vecs.push_back(hz("drop_dstall",    0, 1, 0, 1, 0, 0, 0, 5'd0, E_HOLD,  8, 2));
        vecs.push_back(hz("drop_stale",     0, 1, 0, 0, 0, 0, 0, 5'd0, E_STALE, 8, 2));
        vecs.push_back(hz("post_drop",      0, 1, 0, 0, 0, 0, 0, 5'd0, E_ADV,   8, 2));
        vecs.push_back(hz("drop_entry2",    0, 0, 0, 0, 0, 1, 0, 5'd0, E_DROP,  8, 2));
        vecs.push_back(hz("rst_in_drop",    1, 1, 0, 0, 0, 0, 0, 5'd0, E_RESET, 9, 2));
        vecs.push_back(hz("init2",          0, 1, 0, 0, 0, 0, 0, 5'd0, E_RESET, 0, 0));
        vecs.push_back(hz("no_drop_after",  0, 1, 0, 0, 0, 0, 0, 5'd0, E_ADV,   0, 0));
        vecs.push_back(fw("fwd_exmem",   5'd5, 1, 5'd5, 1, 5'd5, 5'd0, 2'b01, 2'b00));
        vecs.push_back(fw("fwd_memwb",   5'd5, 0, 5'd5, 1, 5'd5, 5'd0, 2'b10, 2'b00));
        vecs.push_back(fw("fwd_split",   5'd5, 1, 5'd6, 1, 5'd6, 5'd5, 2'b10, 2'b01));
        vecs.push_back(fw("fwd_x0",      5'd0, 1, 5'd0, 1, 5'd0, 5'd0, 2'b00, 2'b00));
        vecs.push_back(fw("fwd_no_we",   5'd9, 0, 5'd9, 0, 5'd9, 5'd9, 2'b00, 2'b00));
        vecs.push_back(fw("fwd_both_ex", 5'd3, 1, 5'd3, 1, 5'd3, 5'd3, 2'b01, 2'b01));
        vecs.push_back(fw("fwd_rs2_wb",  5'd4, 0, 5'd3, 1, 5'd4, 5'd3, 2'b00, 2'b10));

        foreach (vecs[i]) begin
            step(vecs[i]);
        end

        // Long istall run pushes the 4-bit stall counter through its wrap point.
        for (int i = 0; i < 18; i++) begin
            step(hz("wrap_istall", 0, 0, 0, 0, 0, 0, 0, 5'd0, E_HOLD, i, 0));
        end
        step(hz("wrap_after", 0, 1, 0, 0, 0, 0, 0, 5'd0, E_ADV, 18, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core. It consumes the register fields, control-word bits and cache handshakes that the decode/control path places in the pipeline registers. It produces the `control` struct's `rs1mux_sel`, `rs2mux_sel`, `pipe_load_*`, `pipe_rst_*` and `load_pc` fields. It sits beside the datapath and is the single owner of stall, flush and forwarding decisions.

## Interface
Parameters:
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- imem_resp  in  1  I-cache returns the fetch for current PC this cycle
- dmem_resp  in  1  D-cache completes the access in EX/MEM this cycle
- id_rs1, id_rs2  in  5  sources of instruction in IF/ID
- idex_rs1, idex_rs2, idex_rd  in  5  fields in ID/EX
- idex_dcache_read  in  1  ID/EX ctrl_word is a load
- exmem_rd  in  5, exmem_load_regfile  in  1  EX/MEM writeback info
- exmem_dcache_read, exmem_dcache_write  in  1  EX/MEM memory access
- memwb_rd  in  5, memwb_load_regfile  in  1  MEM/WB writeback info
- ex_br_taken  in  1  branch/jump in EX redirects PC
- load_pc  out  1
- pipe_load_ifid/idex/exmem/memwb  out  1 each
- pipe_rst_ifid/idex/exmem/memwb  out  1 each
- rs1mux_sel, rs2mux_sel  out  2  EX operand forwarding select
- stall_cnt, flush_cnt  out  CNT_W  performance counters

## Operation
- FSM states: INIT, RUN, DROP.
- INIT is entered on `rst`. It lasts exactly one cycle after `rst` deasserts.
  - All `pipe_rst_*` = 1, all `pipe_load_*` = 0, `load_pc` = 0.
  - Next state is RUN.
- Stall conditions in RUN, all evaluated in the same cycle:
  - dstall = (exmem_dcache_read | exmem_dcache_write) & ~dmem_resp.
  - istall = ~imem_resp.
  - Any stall freezes the whole pipe: all `pipe_load_*` = 0, `load_pc` = 0, no resets. `stall_cnt` += 1.
- Flush: `ex_br_taken` with no stall.
  - `load_pc` = 1, `pipe_rst_ifid` = `pipe_rst_idex` = 1.
  - exmem and memwb load normally. `flush_cnt` += 1.
- Load-use: `idex_dcache_read` & idex_rd≠0 & (idex_rd==id_rs1 | idex_rd==id_rs2), with no stall and no flush.
  - `load_pc` = 0, `pipe_load_ifid` = 0, `pipe_rst_idex` = 1 (bubble).
  - exmem and memwb load. `stall_cnt` += 1.
- Priority: dstall = istall > flush > load-use > normal advance.
- Normal advance: all loads = 1, `load_pc` = 1.
- DROP state (in-flight fetch squash):
  - Entered when `ex_br_taken` is seen while istall=1 and dstall=0. The redirect is applied that cycle: `load_pc` = 1, `pipe_rst_ifid`/`pipe_rst_idex` = 1.
  - In that cycle the whole pipe otherwise holds (exmem/memwb load = 0).
  - In DROP, the first `imem_resp` belongs to the stale fetch. That cycle: `pipe_rst_ifid` = 1, `load_pc` = 0, other stages hold. Then return to RUN.
  - While in DROP and `imem_resp` = 0, everything holds.
  - A dstall in DROP holds everything.
- Forwarding, combinational, per operand (rs1 shown; rs2 identical):
  - 2'b01 if exmem_load_regfile & exmem_rd≠0 & exmem_rd==idex_rs1.
  - else 2'b10 if memwb_load_regfile & memwb_rd≠0 & memwb_rd==idex_rs1.
  - else 2'b00. 2'b11 is never driven.
- Counters wrap modulo 2^CNT_W and do not count during INIT or during `rst`.

## Timing
- Reset values during the `rst` cycle and INIT:
  - `pipe_rst_*` = 1, `pipe_load_*` = 0, `load_pc` = 0.
  - sel = 00, counters = 0, state = INIT.
- All stall/flush/load outputs are combinational from inputs and the registered state, so they take effect the same cycle. Only state and counters are registered.
- Load-use costs exactly one bubble cycle. Branch flush costs two squashed slots.
- `rst` asserted mid-stall or in DROP: next cycle is INIT and all pending state is discarded.
- Simultaneous `ex_br_taken` and load-use: flush wins and no bubble is inserted.

## Structure
- Add to the shared control package: `fwd_sel_t` enum (FWD_NONE = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10) and `hazard_state_t` (INIT, RUN, DROP).
- One sub-module, `forwarding_unit`: purely combinational, instantiated once, producing both selects.
- FSM and counters live in `hazard_ctrl`.

## Test plan
- Reset, then `imem_resp` = 1 with no hazards: INIT for 1 cycle with all `pipe_rst_*` = 1, then every `pipe_load_*` = 1 and `load_pc` = 1. Counters stay 0.
- exmem_rd = 5, exmem_load_regfile = 1, memwb_rd = 5, idex_rs1 = 5, idex_rs2 = 0: `rs1mux_sel` = 01, `rs2mux_sel` = 00. Then exmem_load_regfile = 0: `rs1mux_sel` = 10.
- Load in ID/EX with idex_rd = 7 and id_rs2 = 7: exactly one cycle with `pipe_load_ifid` = 0, `load_pc` = 0, `pipe_rst_idex` = 1. `stall_cnt` = 1.
- exmem_dcache_read = 1 with dmem_resp low for 3 cycles while `ex_br_taken` = 1: all loads = 0 for 3 cycles and no flush. The flush fires on the `dmem_resp` cycle. `stall_cnt` = 3, `flush_cnt` = 1.
- `ex_br_taken` with `imem_resp` = 0: FSM goes to DROP. The next `imem_resp` yields `pipe_rst_ifid` = 1 with `load_pc` = 0. The following cycle is a normal advance.
- `rst` pulsed while in DROP: next cycle is INIT, and DROP handling is not applied to the following `imem_resp`.
